// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state type and shift-amount width helper for alu_seq.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_ZERO = 4'd5;
  localparam logic [3:0] OP_ASL1 = 4'd6;
  localparam logic [3:0] OP_BSL1 = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef logic [0:0] state_t;
  localparam state_t S_IDLE = 1'b0;
  localparam state_t S_EXEC = 1'b1;

  function automatic int unsigned shamt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_seq_addsub.sv
// Parametrised ripple-carry adder/subtractor; sub selects a + ~b + 1.
module alu_seq_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  always_comb begin : ripple
    logic             cy;
    logic [WIDTH-1:0] bx;
    bx  = sub ? ~b : b;
    cy  = sub;
    sum = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ bx[i] ^ cy;
      cy     = (a[i] & bx[i]) | (cy & (a[i] ^ bx[i]));
    end
    carry_out = cy;
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative shifts and an optional
// shift-add multiplier (opcode 10) enabled by macro ALU_SEQ_MUL_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero_flag,
  output logic             c_flag,
  output logic             busy
);

  localparam int unsigned    SHW     = shamt_width(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             ge_q, ge_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             cflag_q, cflag_d;

  logic             accept, is_iter, load, last;
  logic [WIDTH-1:0] ld_res, single_res, as_sum;
  logic             ld_carry, ld_ge, single_carry, as_carry;

`ifdef ALU_SEQ_MUL_EN
  // work_q doubles as the multiplier, consumed LSB first
  logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d, prod_sum;
`endif

  alu_seq_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a         (a),
    .b         (b),
    .sub       (opcode == OP_SUB),
    .sum       (as_sum),
    .carry_out (as_carry)
  );

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero_flag = zero_q;
  assign c_flag    = cflag_q;
  assign busy      = (state_q == S_EXEC);

  always_comb begin
    is_iter = (opcode == OP_SHL) || (opcode == OP_SHR);
`ifdef ALU_SEQ_MUL_EN
    is_iter = is_iter || (opcode == OP_MUL);
`endif
  end

  always_comb begin
    single_res   = '0;
    single_carry = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        single_res   = as_sum;
        single_carry = as_carry;
      end
      OP_AND:          single_res = a & b;
      OP_OR:           single_res = a | b;
      OP_XOR:          single_res = a ^ b;
      OP_ASL1:         single_res = {a[WIDTH-2:0], 1'b0};
      OP_BSL1:         single_res = {b[WIDTH-2:0], 1'b0};
      OP_ZERO, OP_MUL: single_res = '0;
      default:         single_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    ge_d        = ge_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    cflag_d     = cflag_q;
    load        = 1'b0;
    last        = 1'b0;
    ld_res      = '0;
    ld_carry    = 1'b0;
    ld_ge       = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    prod_sum    = prod_q;
`endif

    if (state_q == S_IDLE) begin
      if (accept) begin
        if (is_iter) begin
          state_d = S_EXEC;
          op_d    = opcode;
          work_d  = a;
          cnt_d   = b[SHW-1:0];
          ge_d    = (a >= b);
`ifdef ALU_SEQ_MUL_EN
          if (opcode == OP_MUL) begin
            work_d  = b;
            cnt_d   = '0;
            prod_d  = '0;
            mcand_d = {{WIDTH{1'b0}}, a};
          end
`endif
        end else begin
          load     = 1'b1;
          ld_res   = single_res;
          ld_carry = single_carry;
          ld_ge    = (a >= b);
        end
      end
    end else begin
      case (op_q)
        OP_SHL, OP_SHR: begin
          // shamt 0 still spends one EXEC cycle, just without shifting
          if (cnt_q != '0) begin
            work_d = (op_q == OP_SHL) ? (work_q << 1) : (work_q >> 1);
            cnt_d  = cnt_q - CNT_ONE;
          end
          last   = (cnt_q <= CNT_ONE);
          ld_res = work_d;
        end
`ifdef ALU_SEQ_MUL_EN
        OP_MUL: begin
          prod_sum = work_q[0] ? (prod_q + mcand_q) : prod_q;
          prod_d   = prod_sum;
          mcand_d  = mcand_q << 1;
          work_d   = work_q >> 1;
          cnt_d    = cnt_q + CNT_ONE;
          last     = (cnt_q == '1);
          ld_res   = prod_sum[WIDTH-1:0];
          ld_carry = |prod_sum[2*WIDTH-1:WIDTH];
        end
`endif
        default: last = 1'b1;
      endcase
      if (last) begin
        state_d = S_IDLE;
        load    = 1'b1;
        ld_ge   = ge_q;
      end
    end

    if (load) begin
      out_valid_d = 1'b1;
      result_d    = ld_res;
      carry_d     = ld_carry;
      zero_d      = (ld_res == '0);
      cflag_d     = ld_ge;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      ge_q        <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
      cflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      ge_q        <= ge_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      cflag_q     <= cflag_d;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q  <= '0;
      mcand_q <= '0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
    end
  end
`endif

endmodule
